bin2bcd_seq: RTL and testbench

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

---
 rtl/bin2bcd_seq.sv | 122 ++++++++++++
 tb/tb_bin2bcd_seq.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-BCD converter using iterative
// shift-and-add-3 (double dabble), one input bit per clock.
//
// Optional feature macro: BIN2BCD_SAT_EN
//   defined   -> results >= 10000 saturate to 9999 with ovf=1
//   undefined -> bcd is the value mod 10000 and ovf is tied to 0
//
// Handshake: start is sampled only while the FSM is in IDLE (busy=0). An
// accepted start captures bin; busy stays high until the result is
// published. done is a one-cycle pulse in the cycle where bcd/ovf take their
// new value, and busy is already low in that cycle, so a start presented
// alongside done is accepted on the next edge.
module bin2bcd_seq #(
    parameter int BIN_W = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic [15:0]      bcd,
    output logic             ovf,
    output logic [1:0]       o_dbg_state
);

    localparam int CNT_W = $clog2(BIN_W + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       r_state;
    logic [BIN_W-1:0] r_bin;
    logic [19:0]      r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [15:0]      r_bcd;
    logic             r_ovf;

    logic [19:0]      w_adj;
    logic [19:0]      w_acc_next;
    logic [15:0]      w_bcd_res;
    logic             w_ovf_res;

    // Add 3 to every accumulator digit that is 5 or more before the shift.
    always_comb begin
        w_adj = r_acc;
        for (int d = 0; d < 5; d++) begin
            if (r_acc[4*d +: 4] >= 4'd5) begin
                w_adj[4*d +: 4] = r_acc[4*d +: 4] + 4'd3;
            end
        end
        w_acc_next = {w_adj[18:0], r_bin[BIN_W-1]};
    end

    // Final result formatting: saturate or truncate the five-digit value.
    always_comb begin
        w_bcd_res = r_acc[15:0];
        w_ovf_res = 1'b0;
`ifdef BIN2BCD_SAT_EN
        if (r_acc[19:16] != 4'd0) begin
            w_bcd_res = 16'h9999;
            w_ovf_res = 1'b1;
        end
`endif
    end

    // Control FSM, datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_bin   <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_bcd   <= 16'h0000;
            r_ovf   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_bin   <= bin;
                        r_acc   <= '0;
                        r_cnt   <= CNT_W'(BIN_W);
                        r_busy  <= 1'b1;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_acc <= w_acc_next;
                    r_bin <= {r_bin[BIN_W-2:0], 1'b0};
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_bcd   <= w_bcd_res;
                    r_ovf   <= w_ovf_res;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign bcd         = r_bcd;
    assign ovf         = r_ovf;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: directed bench for bin2bcd_seq (BIN_W = 14).
// Expected values come from hand-written constants and a decimal model that
// uses integer division; BIN2BCD_SAT_EN selects the saturating expectations.
module tb_bin2bcd_seq;

  localparam int BIN_W = 14;
  localparam int LAT   = BIN_W + 1;

  logic             clk;
  logic             rst;
  logic             start;
  logic [BIN_W-1:0] bin;
  logic             busy;
  logic             done;
  logic [15:0]      bcd;
  logic             ovf;
  logic [1:0]       dbg_state;

  int n_cmp;
  int n_err;
  int n_done;
  int n_conv;

  bin2bcd_seq #(.BIN_W(BIN_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .bin        (bin),
    .busy       (busy),
    .done       (done),
    .bcd        (bcd),
    .ovf        (ovf),
    .o_dbg_state(dbg_state)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // count every done pulse, sampled away from the active edge
  always @(negedge clk) if (done === 1'b1) n_done++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // decimal reference model
  function automatic logic [15:0] exp_bcd(input int v);
    int m;
    logic [15:0] r;
`ifdef BIN2BCD_SAT_EN
    if (v >= 10000) return 16'h9999;
`endif
    m = v % 10000;
    r = {4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
    return r;
  endfunction

  function automatic logic exp_ovf(input int v);
`ifdef BIN2BCD_SAT_EN
    return (v >= 10000);
`else
    return 1'b0;
`endif
  endfunction

  // wait for done after an accepted start; optionally pulse a stray start
  // (bin=7) so that it is sampled on edge inj
  task automatic wait_done(input int inj, output int lat);
    logic [15:0] held;
    bit bad_busy;
    bit bad_hold;
    held = bcd;
    bad_busy = 0;
    bad_hold = 0;
    lat = 0;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk); #1;
      lat = e;
      if (e == inj - 1) begin start = 1'b1; bin = 7; end
      if (e == inj) start = 1'b0;
      if (done === 1'b1) break;
      if (busy !== 1'b1) bad_busy = 1;
      if (bcd !== held) bad_hold = 1;
    end
    check("busy_during", 32'(bad_busy), 32'd0);
    check("bcd_hold", 32'(bad_hold), 32'd0);
    check("done_seen", 32'(done), 32'd1);
  endtask

  // driver: present start with v, then scramble bin after the accept edge
  task automatic do_conv(input int v, input int inj, input string tag);
    int lat;
    bin = BIN_W'(v);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    bin = BIN_W'($urandom_range(0, 16383));
    check({tag, "_busy_acc"}, 32'(busy), 32'd1);
    wait_done(inj, lat);
    n_conv++;
    check({tag, "_lat"}, 32'(lat), 32'(LAT));
    check({tag, "_busy_done"}, 32'(busy), 32'd0);
    check({tag, "_bcd"}, 32'(bcd), 32'(exp_bcd(v)));
    check({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf(v)));
  endtask

  initial begin
    int d0;
    n_cmp = 0; n_err = 0; n_done = 0; n_conv = 0;
    rst = 1'b1; start = 1'b0; bin = '0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bcd", 32'(bcd), 32'h0000);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;

    // first start right after reset release, bin = 0
    do_conv(0, -1, "zero");
    check("zero_bcd_const", 32'(bcd), 32'h0000);

    // back-to-back: second start issued in the done cycle
    do_conv(255, -1, "b2b_a");
    check("b2b_a_const", 32'(bcd), 32'h0255);
    do_conv(9999, -1, "b2b_b");
    check("b2b_b_const", 32'(bcd), 32'h9999);

    // overflow region
    do_conv(12345, -1, "ovf12345");
`ifdef BIN2BCD_SAT_EN
    check("ovf12345_const", 32'({ovf, bcd}), 32'h1_9999);
`else
    check("ovf12345_const", 32'({ovf, bcd}), 32'h0_2345);
`endif
    do_conv(16383, -1, "max");
    do_conv(10000, -1, "tenk");

    // assorted hand-picked values
    do_conv(9, -1, "d9");
    check("d9_const", 32'(bcd), 32'h0009);
    do_conv(10, -1, "d10");
    check("d10_const", 32'(bcd), 32'h0010);
    do_conv(1000, -1, "d1000");
    check("d1000_const", 32'(bcd), 32'h1000);
    do_conv(4095, -1, "d4095");
    check("d4095_const", 32'(bcd), 32'h4095);

    // stray start while busy is ignored
    @(posedge clk); #1;
    d0 = n_done;
    do_conv(42, 5, "ign");
    check("ign_const", 32'(bcd), 32'h0042);
    repeat (20) @(posedge clk);
    #1;
    check("ign_one_done", 32'(n_done - d0), 32'd1);

    // reset mid-conversion aborts
    d0 = n_done;
    bin = 500; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_bcd", 32'(bcd), 32'h0000);
    check("abort_state", 32'(dbg_state), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("abort_no_done", 32'(n_done - d0), 32'd0);
    check("abort_bcd_hold", 32'(bcd), 32'h0000);
    do_conv(500, -1, "after_abort");
    check("after_abort_const", 32'(bcd), 32'h0500);

    // strided sweep against the decimal model
    for (int v = 0; v < 16384; v += 13) do_conv(v, -1, "sweep");

    // total done pulses equals completed conversions
    repeat (3) @(posedge clk);
    #1;
    check("done_total", 32'(n_done), 32'(n_conv));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
